// File: rtl/irq_pkg.sv
// Shared types for the interrupt priority controller: arbitration mode and
// request FSM state encodings.
package irq_pkg;

  typedef enum logic {
    ARB_FIXED,
    ARB_RR
  } arb_mode_t;

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational rotating priority encoder: first set bit of req scanning from
// ptr upward with wrap, returned as an absolute index.
module irq_prio_enc #(
  parameter int unsigned N_IRQ = 4,
  localparam int unsigned ID_W = $clog2(N_IRQ)
) (
  input  logic [N_IRQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  id
);

  logic [2*N_IRQ-1:0] dbl;
  logic [N_IRQ-1:0]   rot;
  logic [ID_W-1:0]    pos;
  logic [ID_W:0]      sum;

  // Rotate so ptr lands at bit 0, pick the lowest bit, then rotate back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[N_IRQ-1:0];
    valid = |rot;
    pos   = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (rot[i]) pos = ID_W'(i);
    end
    sum = (ID_W+1)'(pos) + (ID_W+1)'(ptr);
    if (sum >= (ID_W+1)'(N_IRQ)) sum = sum - (ID_W+1)'(N_IRQ);
    id = sum[ID_W-1:0];
  end

endmodule

// File: rtl/irq_priority_ctrl.sv
// N-source registered interrupt controller: pending/overrun latches, masking,
// fixed or round-robin arbitration and a req/ack handshake toward the CPU.
module irq_priority_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned N_IRQ     = 4,
  parameter bit          EDGE_MODE = 1'b1,
  parameter arb_mode_t   ARB_MODE  = ARB_FIXED,
  localparam int unsigned ID_W     = $clog2(N_IRQ)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic [N_IRQ-1:0] irq_mask,
  input  logic             irq_ack,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_IRQ-1:0] irq_onehot,
  output logic [N_IRQ-1:0] irq_pend,
  output logic [N_IRQ-1:0] irq_ovr
);

  state_t             state, state_d;
  logic [N_IRQ-1:0]   irq_q;
  logic [ID_W-1:0]    rr_ptr, rr_d;
  logic [ID_W-1:0]    id_d;
  logic [N_IRQ-1:0]   onehot_d;
  logic [N_IRQ-1:0]   set_c, clr_c, eligible_c, pend_d, ovr_d;
  logic               hs_c;
  logic [ID_W-1:0]    enc_ptr;
  logic               enc_valid;
  logic [ID_W-1:0]    enc_id;

  assign irq_req = (state == REQ);
  assign enc_ptr = (ARB_MODE == ARB_RR) ? rr_ptr : '0;

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_enc (
    .req   (eligible_c),
    .ptr   (enc_ptr),
    .valid (enc_valid),
    .id    (enc_id)
  );

  // Pending/overrun update; a new set event beats a same-cycle clear.
  always_comb begin
    hs_c       = (state == REQ) && irq_ack;
    set_c      = EDGE_MODE ? (irq_in & ~irq_q) : irq_in;
    clr_c      = hs_c ? (N_IRQ'(1) << irq_id) : '0;
    pend_d     = (irq_pend & ~clr_c) | set_c;
    ovr_d      = (irq_ovr | (EDGE_MODE ? (set_c & irq_pend & ~clr_c) : '0)) & ~clr_c;
    eligible_c = irq_pend & irq_mask;
  end

  // Request FSM: arbitrate in IDLE, hold the grant frozen in REQ until ack.
  always_comb begin
    state_d  = state;
    id_d     = irq_id;
    onehot_d = irq_onehot;
    rr_d     = rr_ptr;
    unique case (state)
      IDLE: begin
        if (enc_valid) begin
          state_d  = REQ;
          id_d     = enc_id;
          onehot_d = N_IRQ'(1) << enc_id;
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_d  = IDLE;
          onehot_d = '0;
          if (ARB_MODE == ARB_RR) begin
            rr_d = (irq_id == ID_W'(N_IRQ - 1)) ? '0 : irq_id + ID_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      irq_q      <= '0;
      irq_pend   <= '0;
      irq_ovr    <= '0;
      irq_id     <= '0;
      irq_onehot <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= state_d;
      irq_q      <= irq_in;
      irq_pend   <= pend_d;
      irq_ovr    <= ovr_d;
      irq_id     <= id_d;
      irq_onehot <= onehot_d;
      rr_ptr     <= rr_d;
    end
  end

  a_onehot: assert property (@(posedge clock) $onehot0(irq_onehot));
  a_id_range: assert property (@(posedge clock) {1'b0, irq_id} < (ID_W+1)'(N_IRQ));
  a_id_stable: assert property (@(posedge clock) disable iff (reset)
                                (irq_req && !irq_ack) |=> $stable(irq_id));

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scoreboard bench for irq_priority_ctrl: three instances (fixed/edge,
// round-robin/edge, fixed/level) driven from hand-built expectation tables.
module tb_irq_priority_ctrl;
  import irq_pkg::*;

  localparam int unsigned A = 0, B = 10, C = 20;
  localparam int unsigned F_REQ = 0, F_ID = 1, F_OH = 2, F_PEND = 3, F_OVR = 4;

  typedef struct {
    string       tag;
    int unsigned src;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, b_rst, c_rst;
  logic [3:0] a_in, b_in, c_in, a_mask, b_mask, c_mask;
  logic       a_ack, b_ack, c_ack;
  logic       a_req, b_req, c_req;
  logic [1:0] a_id, b_id, c_id;
  logic [3:0] a_oh, b_oh, c_oh, a_pend, b_pend, c_pend, a_ovr, b_ovr, c_ovr;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  irq_priority_ctrl #(.N_IRQ(4), .EDGE_MODE(1'b1), .ARB_MODE(ARB_FIXED)) u_fix (
    .clock(clk), .reset(a_rst), .irq_in(a_in), .irq_mask(a_mask), .irq_ack(a_ack),
    .irq_req(a_req), .irq_id(a_id), .irq_onehot(a_oh), .irq_pend(a_pend), .irq_ovr(a_ovr));

  irq_priority_ctrl #(.N_IRQ(4), .EDGE_MODE(1'b1), .ARB_MODE(ARB_RR)) u_rr (
    .clock(clk), .reset(b_rst), .irq_in(b_in), .irq_mask(b_mask), .irq_ack(b_ack),
    .irq_req(b_req), .irq_id(b_id), .irq_onehot(b_oh), .irq_pend(b_pend), .irq_ovr(b_ovr));

  irq_priority_ctrl #(.N_IRQ(4), .EDGE_MODE(1'b0), .ARB_MODE(ARB_FIXED)) u_lvl (
    .clock(clk), .reset(c_rst), .irq_in(c_in), .irq_mask(c_mask), .irq_ack(c_ack),
    .irq_req(c_req), .irq_id(c_id), .irq_onehot(c_oh), .irq_pend(c_pend), .irq_ovr(c_ovr));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] observe(input int unsigned src);
    case (src)
      A + F_REQ:  return 32'(a_req);
      A + F_ID:   return 32'(a_id);
      A + F_OH:   return 32'(a_oh);
      A + F_PEND: return 32'(a_pend);
      A + F_OVR:  return 32'(a_ovr);
      B + F_REQ:  return 32'(b_req);
      B + F_ID:   return 32'(b_id);
      B + F_OH:   return 32'(b_oh);
      B + F_PEND: return 32'(b_pend);
      B + F_OVR:  return 32'(b_ovr);
      C + F_REQ:  return 32'(c_req);
      C + F_ID:   return 32'(c_id);
      C + F_OH:   return 32'(c_oh);
      C + F_PEND: return 32'(c_pend);
      C + F_OVR:  return 32'(c_ovr);
      default:    return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic want(input string tag, input int unsigned src, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.src = src;
    e.exp = v;
    sb.push_back(e);
  endtask

  // Expected full output state of one instance after the coming edge.
  task automatic want_state(input string tag, input int unsigned inst, input logic req,
                            input int unsigned id, input logic [31:0] pend, input logic [31:0] ovr);
    want($sformatf("%s.req", tag),  inst + F_REQ,  32'(req));
    want($sformatf("%s.id", tag),   inst + F_ID,   32'(id));
    want($sformatf("%s.oh", tag),   inst + F_OH,   req ? (32'(1) << id) : 32'(0));
    want($sformatf("%s.pend", tag), inst + F_PEND, pend);
    want($sformatf("%s.ovr", tag),  inst + F_OVR,  ovr);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.src), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_in = '0; b_in = '0; c_in = '0;
    a_mask = 4'hF; b_mask = 4'hF; c_mask = 4'hF;
    a_ack = 1'b0; b_ack = 1'b0; c_ack = 1'b0;
    tick();
    want_state("rst_a", A, 1'b0, 0, 0, 0);
    want_state("rst_b", B, 1'b0, 0, 0, 0);
    want_state("rst_c", C, 1'b0, 0, 0, 0);
    tick();
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    tick();

    // Fixed priority: two sources pulsed together, served low index first
    a_in = 4'b1010; want_state("t1_latch", A, 1'b0, 0, 32'hA, 0); tick();
    a_in = 4'b0000; want_state("t1_grant1", A, 1'b1, 1, 32'hA, 0); tick();
    want_state("t1_hold", A, 1'b1, 1, 32'hA, 0); tick();
    a_ack = 1'b1; want_state("t1_ack1", A, 1'b0, 1, 32'h8, 0); tick();
    a_ack = 1'b0; want_state("t1_grant3", A, 1'b1, 3, 32'h8, 0); tick();
    a_ack = 1'b1; want_state("t1_ack3", A, 1'b0, 3, 0, 0); tick();
    want_state("idle_stray_ack", A, 1'b0, 3, 0, 0); tick();
    a_ack = 1'b0;

    // Masked pending is held, then granted as soon as the mask opens
    a_mask = 4'h0; a_in = 4'b0001; want_state("t3_latch", A, 1'b0, 3, 32'h1, 0); tick();
    a_in = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      want_state($sformatf("t3_masked%0d", i), A, 1'b0, 3, 32'h1, 0);
      tick();
    end
    a_mask = 4'hF; want_state("t3_unmask", A, 1'b1, 0, 32'h1, 0); tick();
    a_ack = 1'b1; want_state("t3_ack", A, 1'b0, 0, 0, 0); tick();
    a_ack = 1'b0;

    // Overrun, then set and ack on the same channel in the same cycle
    a_in = 4'b0100; want_state("t4_latch", A, 1'b0, 0, 32'h4, 0); tick();
    a_in = 4'b0000; want_state("t4_grant", A, 1'b1, 2, 32'h4, 0); tick();
    a_in = 4'b0100; want_state("t4_ovr", A, 1'b1, 2, 32'h4, 32'h4); tick();
    a_in = 4'b0000; want_state("t4_hold", A, 1'b1, 2, 32'h4, 32'h4); tick();
    a_in = 4'b0100; a_ack = 1'b1; want_state("t4_set_ack", A, 1'b0, 2, 32'h4, 0); tick();
    a_in = 4'b0000; a_ack = 1'b0; want_state("t4_regrant", A, 1'b1, 2, 32'h4, 0); tick();

    // Reset in the middle of a request drops the grant
    a_rst = 1'b1; want_state("t5_reset", A, 1'b0, 0, 0, 0); tick();
    a_rst = 1'b0; a_ack = 1'b1; want_state("t5_stray", A, 1'b0, 0, 0, 0); tick();
    a_ack = 1'b0;

    // Round-robin: pointer advances past each acked source and wraps
    b_in = 4'hF; want_state("t2_latch", B, 1'b0, 0, 32'hF, 0); tick();
    want_state("t2_grant0", B, 1'b1, 0, 32'hF, 0); tick();
    for (int k = 0; k < 4; k++) begin
      b_ack = 1'b1;
      b_in  = 4'hF & ~(4'(1) << k);
      want_state($sformatf("t2_ack%0d", k), B, 1'b0, k, 32'hF & ~(32'(1) << k), 0);
      tick();
      b_ack = 1'b0;
      b_in  = 4'hF;
      want_state($sformatf("t2_next%0d", k), B, 1'b1, (k + 1) % 4, 32'hF, 0);
      tick();
    end

    // Level mode: a held line re-pends on ack and never flags overrun
    c_in = 4'b0010; want_state("t6_latch", C, 1'b0, 0, 32'h2, 0); tick();
    want_state("t6_grant", C, 1'b1, 1, 32'h2, 0); tick();
    c_ack = 1'b1; want_state("t6_ack", C, 1'b0, 1, 32'h2, 0); tick();
    c_ack = 1'b0; want_state("t6_regrant", C, 1'b1, 1, 32'h2, 0); tick();
    want_state("t6_hold", C, 1'b1, 1, 32'h2, 0); tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
